// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM encoding and step-count helper for alu_seq
package alu_pkg;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_SL  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Number of single-bit steps an op needs; d2 carries DATA2 zero-extended, width < 64.
  function automatic logic [31:0] step_count(input logic [2:0] sel,
                                             input logic [63:0] d2,
                                             input int width);
    logic [63:0] mask;
    logic [63:0] sign_bit;
    logic [63:0] wid;
    logic [63:0] mag;
    logic [63:0] r;
    mask     = (64'd1 << width) - 64'd1;
    sign_bit = mask ^ (mask >> 1);
    wid      = 64'(width);
    mag      = d2 & mask;
    r        = '0;
    case (sel)
      OP_ROR: r = mag % wid;
      OP_SRA: r = (mag > wid) ? wid : mag;
      OP_SL: begin
        if ((d2 & sign_bit) != 64'd0) begin
          mag = (~d2 + 64'd1) & mask;
        end
        r = (mag > wid) ? wid : mag;
      end
      OP_MUL:  r = wid;
      default: r = '0;
    endcase
    return r[31:0];
  endfunction

endpackage

// File: rtl/alu_step_unit.sv
// rtl/alu_step_unit.sv - one iteration of rotate / shift / shift-add multiply
module alu_step_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic             shift_left,
  input  logic [WIDTH-1:0] work,
  input  logic [WIDTH-1:0] acc,
  input  logic             mbit,
  output logic [WIDTH-1:0] work_next,
  output logic [WIDTH-1:0] acc_next
);

  always_comb begin
    work_next = work;
    acc_next  = acc;
    case (op)
      OP_ROR: work_next = {work[0], work[WIDTH-1:1]};
      OP_SRA: work_next = {work[WIDTH-1], work[WIDTH-1:1]};
      OP_SL: begin
        if (shift_left) begin
          work_next = {work[WIDTH-2:0], 1'b0};
        end else begin
          work_next = {1'b0, work[WIDTH-1:1]};
        end
      end
      OP_MUL: begin
        // work holds the multiplicand, doubled each step; carries out of acc are dropped
        work_next = {work[WIDTH-2:0], 1'b0};
        acc_next  = mbit ? (acc + work) : acc;
      end
      default: begin
        work_next = work;
        acc_next  = acc;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU with START/READY/DONE handshake
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic             READY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             OVERFLOW
);

  localparam int CNTW = $clog2(WIDTH) + 1;

  state_t           state;
  state_t           state_next;
  logic [2:0]       op_r;
  logic             dir_r;
  logic [WIDTH-1:0] work_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] mult_r;
  logic [CNTW-1:0]  cnt_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             ovf_r;

  logic             accept;
  logic [CNTW-1:0]  k;
  logic             stepping;
  logic             last_step;
  logic [2:0]       in_op;
  logic             in_dir;
  logic [WIDTH-1:0] in_work;
  logic [WIDTH-1:0] in_acc;
  logic [WIDTH-1:0] in_mult;
  logic [CNTW-1:0]  in_cnt;
  logic [WIDTH-1:0] work_next;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] step_result;
  logic [WIDTH-1:0] sum;
  logic             add_ovf;
  logic [WIDTH-1:0] quick_result;

  assign accept = START && (state != EXEC);
  assign k      = CNTW'(step_count(SELECT, 64'(DATA2), WIDTH));

  // The accept edge already performs the first step, so EXEC lasts k-1 cycles.
  assign stepping  = (state == EXEC) || (accept && (k != '0));
  assign in_op     = (state == EXEC) ? op_r   : SELECT;
  assign in_dir    = (state == EXEC) ? dir_r  : ~DATA2[WIDTH-1];
  assign in_work   = (state == EXEC) ? work_r : DATA1;
  assign in_acc    = (state == EXEC) ? acc_r  : '0;
  assign in_mult   = (state == EXEC) ? mult_r : DATA2;
  assign in_cnt    = (state == EXEC) ? cnt_r  : k;
  assign last_step = stepping && (in_cnt == CNTW'(1));

  alu_step_unit #(.WIDTH(WIDTH)) u_step (
    .op         (in_op),
    .shift_left (in_dir),
    .work       (in_work),
    .acc        (in_acc),
    .mbit       (in_mult[0]),
    .work_next  (work_next),
    .acc_next   (acc_next)
  );

  assign step_result = (in_op == OP_MUL) ? acc_next : work_next;

  assign sum     = DATA1 + DATA2;
  assign add_ovf = (DATA1[WIDTH-1] == DATA2[WIDTH-1]) && (sum[WIDTH-1] != DATA1[WIDTH-1]);

  // Zero-step rotates and shifts leave the operand unchanged.
  always_comb begin
    quick_result = DATA1;
    case (SELECT)
      OP_FWD:  quick_result = DATA2;
      OP_ADD:  quick_result = sum;
      OP_AND:  quick_result = DATA1 & DATA2;
      OP_OR:   quick_result = DATA1 | DATA2;
      default: quick_result = DATA1;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, FIN: begin
        if (accept) begin
          state_next = (k <= CNTW'(1)) ? FIN : EXEC;
        end else begin
          state_next = IDLE;
        end
      end
      EXEC: begin
        if (cnt_r == CNTW'(1)) begin
          state_next = FIN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      op_r     <= '0;
      dir_r    <= 1'b0;
      work_r   <= '0;
      acc_r    <= '0;
      mult_r   <= '0;
      cnt_r    <= '0;
      result_r <= '0;
      zero_r   <= 1'b1;
      ovf_r    <= 1'b0;
    end else begin
      state <= state_next;
      if (stepping) begin
        op_r   <= in_op;
        dir_r  <= in_dir;
        work_r <= work_next;
        acc_r  <= acc_next;
        mult_r <= in_mult >> 1;
        cnt_r  <= in_cnt - CNTW'(1);
      end
      if (accept && (k == '0)) begin
        result_r <= quick_result;
        zero_r   <= (quick_result == '0);
        ovf_r    <= (SELECT == OP_ADD) && add_ovf;
      end else if (last_step) begin
        result_r <= step_result;
        zero_r   <= (step_result == '0);
        ovf_r    <= 1'b0;
      end
    end
  end

  assign READY    = (state != EXEC);
  assign DONE     = (state == FIN);
  assign RESULT   = result_r;
  assign ZERO     = zero_r;
  assign OVERFLOW = ovf_r;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;
  import alu_pkg::*;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic [2:0] SELECT;
  logic [7:0] DATA1;
  logic [7:0] DATA2;
  logic       READY;
  logic       DONE;
  logic [7:0] RESULT;
  logic       ZERO;
  logic       OVERFLOW;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(8)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .START    (START),
    .SELECT   (SELECT),
    .DATA1    (DATA1),
    .DATA2    (DATA2),
    .READY    (READY),
    .DONE     (DONE),
    .RESULT   (RESULT),
    .ZERO     (ZERO),
    .OVERFLOW (OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one op (READY must be 1) and counts edges from the accept edge to DONE.
  task automatic run_op(input logic [2:0] sel, input logic [7:0] d1, input logic [7:0] d2,
                        output int lat, output int ready_low);
    START  = 1'b1;
    SELECT = sel;
    DATA1  = d1;
    DATA2  = d2;
    @(posedge CLK); #1;
    START     = 1'b0;
    lat       = 1;
    ready_low = 0;
    while (!DONE && lat < 40) begin
      if (!READY) ready_low++;
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  task automatic idle_cycle();
    @(posedge CLK); #1;
  endtask

  initial begin
    int         lat;
    int         rl;
    int         dones;
    logic [7:0] got;

    RESET  = 1'b1;
    START  = 1'b0;
    SELECT = OP_FWD;
    DATA1  = 8'h00;
    DATA2  = 8'h00;
    got    = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ready", READY, 1);
    check("rst_done", DONE, 0);
    check("rst_result", RESULT, 8'h00);
    check("rst_zero", ZERO, 1);
    check("rst_ovf", OVERFLOW, 0);
    RESET = 1'b0;

    run_op(OP_ADD, 8'h7F, 8'h01, lat, rl);
    check("add1_lat", lat, 1);
    check("add1_result", RESULT, 8'h80);
    check("add1_ovf", OVERFLOW, 1);
    check("add1_zero", ZERO, 0);
    run_op(OP_ADD, 8'h05, 8'hFB, lat, rl);
    check("add2_lat", lat, 1);
    check("add2_result", RESULT, 8'h00);
    check("add2_zero", ZERO, 1);
    check("add2_ovf", OVERFLOW, 0);
    idle_cycle();
    check("done_pulse", DONE, 0);

    run_op(OP_MUL, 8'h0D, 8'h0B, lat, rl);
    check("mul1_lat", lat, 8);
    check("mul1_ready_low", rl, 7);
    check("mul1_result", RESULT, 8'h8F);
    idle_cycle();
    run_op(OP_MUL, 8'h10, 8'h10, lat, rl);
    check("mul2_result", RESULT, 8'h00);
    check("mul2_zero", ZERO, 1);
    idle_cycle();

    run_op(OP_SRA, 8'h90, 8'h03, lat, rl);
    check("sra_result", RESULT, 8'hF2);
    check("sra_lat", lat, 3);
    idle_cycle();
    run_op(OP_ROR, 8'h81, 8'h01, lat, rl);
    check("ror1_result", RESULT, 8'hC0);
    check("ror1_lat", lat, 1);
    idle_cycle();
    run_op(OP_ROR, 8'h81, 8'h09, lat, rl);
    check("ror9_result", RESULT, 8'hC0);
    check("ror9_lat", lat, 1);
    idle_cycle();

    run_op(OP_SL, 8'h81, 8'h02, lat, rl);
    check("sl_p2_result", RESULT, 8'h04);
    check("sl_p2_lat", lat, 2);
    idle_cycle();
    run_op(OP_SL, 8'h81, 8'hFE, lat, rl);
    check("sl_m2_result", RESULT, 8'h20);
    check("sl_m2_lat", lat, 2);
    idle_cycle();
    run_op(OP_SL, 8'h81, 8'h80, lat, rl);
    check("sl_min_result", RESULT, 8'h00);
    check("sl_min_zero", ZERO, 1);
    check("sl_min_lat", lat, 8);
    idle_cycle();

    // ADD request and operand changes during MUL's EXEC must be ignored
    START  = 1'b1;
    SELECT = OP_MUL;
    DATA1  = 8'h0D;
    DATA2  = 8'h0B;
    @(posedge CLK); #1;
    START = 1'b0;
    dones = 0;
    for (int j = 0; j < 14; j++) begin
      if (DONE) begin
        dones++;
        got = RESULT;
      end
      if (j == 2) begin
        START  = 1'b1;
        SELECT = OP_ADD;
        DATA1  = 8'h7F;
        DATA2  = 8'h01;
      end else begin
        START = 1'b0;
      end
      @(posedge CLK); #1;
    end
    check("ign_dones", dones, 1);
    check("ign_result", got, 8'h8F);
    check("ign_ovf", OVERFLOW, 0);

    START  = 1'b1;
    SELECT = OP_MUL;
    DATA1  = 8'h0D;
    DATA2  = 8'h0B;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    check("abort_ready", READY, 1);
    check("abort_done", DONE, 0);
    check("abort_result", RESULT, 8'h00);
    check("abort_zero", ZERO, 1);
    check("abort_ovf", OVERFLOW, 0);
    dones = 0;
    for (int j = 0; j < 10; j++) begin
      if (DONE) dones++;
      @(posedge CLK); #1;
    end
    check("abort_no_done", dones, 0);

    run_op(OP_FWD, 8'h00, 8'h5A, lat, rl);
    check("fwd_result", RESULT, 8'h5A);
    check("fwd_lat", lat, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
